// File: rtl/pio_avalon_master.sv
// pio_avalon_master: buffers valid/ready commands in a small FIFO and replays
// them as single-word Avalon-MM reads/writes, one outstanding at a time.
module pio_avalon_master #(
    parameter int ADDR_W       = 2,
    parameter int FIFO_DEPTH   = 4,
    parameter int READ_LATENCY = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_address,
    input  logic [31:0]       cmd_writedata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_readdata,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_chipselect,
    output logic              avm_write_n,
    output logic              avm_read_n,
    output logic [31:0]       avm_writedata,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_waitrequest,
    output logic              busy
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int EW = 33 + ADDR_W;
    localparam logic [1:0] LAT = 2'(READ_LATENCY);

    typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT} state_t;

    // Command FIFO: one extra pointer bit distinguishes full from empty.
    logic [EW-1:0]     fifo_mem [FIFO_DEPTH];
    logic [PW:0]       wr_ptr_q, wr_ptr_d;
    logic [PW:0]       rd_ptr_q, rd_ptr_d;
    logic              fifo_empty, fifo_full;
    logic              push, pop;
    logic [EW-1:0]     head;
    logic              head_write;
    logic [ADDR_W-1:0] head_addr;
    logic [31:0]       head_data;

    state_t            state_q;
    logic [1:0]        cnt_q;
    logic              rsp_valid_q;
    logic [31:0]       rsp_data_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              cs_q, write_n_q, read_n_q;
    logic              issue_done;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                        (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    // Pushing depends only on the current fullness, never on a same-cycle pop.
    assign push       = cmd_valid && !fifo_full;

    assign head       = fifo_mem[rd_ptr_q[PW-1:0]];
    assign head_write = head[EW-1];
    assign head_addr  = head[EW-2 -: ADDR_W];
    assign head_data  = head[31:0];

    // Bus transaction accepted by the slave this cycle.
    assign issue_done = (state_q == ISSUE) && !avm_waitrequest;

    // Pop whenever the bus becomes free in this cycle and a command is waiting.
    // A read with nonzero latency frees the bus only at the end of RDWAIT.
    assign pop = !fifo_empty &&
                 ((state_q == IDLE) ||
                  (issue_done && (read_n_q || (LAT == 2'd0))) ||
                  ((state_q == RDWAIT) && (cnt_q == 2'd1)));

    assign wr_ptr_d = wr_ptr_q + (PW+1)'(push);
    assign rd_ptr_d = rd_ptr_q + (PW+1)'(pop);

    // Storage array: written on push, no reset needed for the payload.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q[PW-1:0]] <= {cmd_write, cmd_address, cmd_writedata};
        end
    end

    // FIFO pointers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Transaction FSM with registered bus and response outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 2'd0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cs_q        <= 1'b0;
            write_n_q   <= 1'b1;
            read_n_q    <= 1'b1;
        end else begin
            rsp_valid_q <= 1'b0;

            // A pop always loads the bus registers and raises the strobes;
            // the state cases below only deassert when nothing is popped.
            if (pop) begin
                addr_q    <= head_addr;
                wdata_q   <= head_data;
                cs_q      <= 1'b1;
                write_n_q <= !head_write;
                read_n_q  <= head_write;
            end

            case (state_q)
                IDLE: begin
                    if (pop) begin
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!avm_waitrequest) begin
                        if (!read_n_q && (LAT == 2'd0)) begin
                            rsp_data_q  <= avm_readdata;
                            rsp_valid_q <= 1'b1;
                        end
                        if (!read_n_q && (LAT != 2'd0)) begin
                            cs_q     <= 1'b0;
                            read_n_q <= 1'b1;
                            cnt_q    <= LAT;
                            state_q  <= RDWAIT;
                        end else if (!pop) begin
                            cs_q      <= 1'b0;
                            write_n_q <= 1'b1;
                            read_n_q  <= 1'b1;
                            state_q   <= IDLE;
                        end
                    end
                end
                RDWAIT: begin
                    cnt_q <= cnt_q - 2'd1;
                    if (cnt_q == 2'd1) begin
                        rsp_data_q  <= avm_readdata;
                        rsp_valid_q <= 1'b1;
                        state_q     <= pop ? ISSUE : IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready      = !fifo_full;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_readdata   = rsp_data_q;
    assign avm_address    = addr_q;
    assign avm_writedata  = wdata_q;
    assign avm_chipselect = cs_q;
    assign avm_write_n    = write_n_q;
    assign avm_read_n     = read_n_q;
    assign busy           = !fifo_empty || (state_q != IDLE);

endmodule
